// File: rtl/tick_rr_arbiter.sv
// Round-robin arbiter for the flag-gated AND datapath. A programmable divider
// produces a tick; grants start on a tick and the tick is forwarded only to the owner.
module tick_rr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DIV_W     = 8,
    parameter int DEF_DIV   = 4,
    parameter int OWN_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_load,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [2:0]       owner_id,
    output logic             busy,
    output logic             tick,
    output logic             po_flag
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [7:0]       OWN_LAST = 8'(OWN_TICKS - 1);
    localparam logic [2:0]       PTR_LAST = 3'(NREQ - 1);

    state_t           state_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] div_reg;
    logic [2:0]       ptr_reg;
    logic [7:0]       own_cnt_reg;
    logic [NREQ-1:0]  gnt_reg;
    logic [2:0]       owner_reg;
    logic             busy_reg;

    logic [7:0]       req_ext;
    logic [2:0]       cand_idx [NREQ];
    logic [2:0]       sel;
    logic             sel_valid;
    logic [NREQ-1:0]  sel_onehot;
    logic             release_hit;

    // Divider: tick marks the last count of the current period.
    assign tick = (cnt_reg == div_reg - DIV_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            div_reg <= DIV_W'(DEF_DIV);
        end else if (cfg_load) begin
            div_reg <= (cfg_div == '0) ? DIV_ONE : cfg_div;
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + DIV_ONE;
        end
    end

    // Widened request vector so 3-bit indices always address a full byte.
    assign req_ext = 8'(req);

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_idx[gi] = 3'((32'(ptr_reg) + gi) % NREQ);
        end
    endgenerate

    // Scan from the highest offset down so the offset nearest ptr wins.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_ext[cand_idx[i]]) begin
                sel       = cand_idx[i];
                sel_valid = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign sel_onehot[gi] = (sel == 3'(gi));
        end
    endgenerate

    assign release_hit = !req_ext[owner_reg] || (tick && own_cnt_reg == OWN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            own_cnt_reg <= '0;
            gnt_reg     <= '0;
            owner_reg   <= '0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (tick && sel_valid) begin
                        gnt_reg     <= sel_onehot;
                        owner_reg   <= sel;
                        busy_reg    <= 1'b1;
                        own_cnt_reg <= '0;
                        state_reg   <= OWN;
                    end
                end
                OWN: begin
                    // A release never grants in the same edge; the next grant waits for a tick in IDLE.
                    if (release_hit) begin
                        gnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                        ptr_reg   <= (owner_reg == PTR_LAST) ? 3'd0 : owner_reg + 3'd1;
                    end else if (tick) begin
                        own_cnt_reg <= own_cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt      = gnt_reg;
    assign owner_id = owner_reg;
    assign busy     = busy_reg;
    assign po_flag  = tick & busy_reg;

endmodule

// File: tb/tb_tick_rr_arbiter.sv
// Bench for tick_rr_arbiter: timeline table, directed corner sequences and a
// randomized run against a flag-counting reference model.
module tb_tick_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] cfg_div;
    logic       cfg_load;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [2:0] owner_id;
    logic       busy;
    logic       tick;
    logic       po_flag;

    int n_checks = 0;
    int n_pass   = 0;

    tick_rr_arbiter #(
        .NREQ(4), .DIV_W(8), .DEF_DIV(4), .OWN_TICKS(3)
    ) dut (
        .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_load(cfg_load), .req(req),
        .gnt(gnt), .owner_id(owner_id), .busy(busy), .tick(tick), .po_flag(po_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       exp_tick;
        logic [3:0] exp_gnt;
        logic       exp_po;
    } vec_t;

    vec_t tbl [24];

    // Reference model: phase within period, owner (-1 = none), flags delivered.
    int m_phase, m_period, m_owner, m_flags, m_ptr, m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        cfg_load = 1'b0;
        adv();
        rst = 1'b0;
    endtask

    task automatic model_step();
        bit t;
        int nf;
        t = (m_phase == m_period - 1);
        if (rst) begin
            m_phase = 0; m_period = 4; m_owner = -1; m_flags = 0; m_ptr = 0; m_last = 0;
        end else begin
            if (cfg_load) begin
                m_period = (cfg_div == 0) ? 1 : int'(cfg_div);
                m_phase  = 0;
            end else begin
                m_phase = t ? 0 : m_phase + 1;
            end
            if (m_owner < 0) begin
                if (t && req != 0) begin
                    for (int k = 0; k < 4; k++) begin
                        int c = (m_ptr + k) % 4;
                        if (req[c]) begin
                            m_owner = c; m_last = c; m_flags = 0;
                            break;
                        end
                    end
                end
            end else begin
                nf = m_flags + (t ? 1 : 0);
                if (!req[m_owner] || nf == 3) begin
                    m_ptr   = (m_owner + 1) % 4;
                    m_owner = -1;
                end else begin
                    m_flags = nf;
                end
            end
        end
    endtask

    initial begin
        int owners[$];
        int po_cnt;
        int onehot_bad;
        bit idle_tick_seen;
        bit prev_busy;
        logic [3:0] e_gnt;

        rst = 1'b1; cfg_load = 1'b0; cfg_div = 8'd0; req = 4'b0000;

        // Timeline for req=0001 held from reset release.
        for (int c = 0; c < 24; c++) begin
            tbl[c].req      = 4'b0001;
            tbl[c].exp_tick = (c % 4 == 3);
            tbl[c].exp_gnt  = ((c >= 4 && c <= 15) || c >= 20) ? 4'b0001 : 4'b0000;
            tbl[c].exp_po   = (c == 7 || c == 11 || c == 15 || c == 23);
        end

        // Reset state and idle ticking.
        do_reset();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_po", 32'(po_flag), 0);
        chk("rst_owner", 32'(owner_id), 0);
        for (int c = 0; c < 13; c++) begin
            chk($sformatf("idle_tick_c%0d", c), 32'(tick), 32'(c == 3 || c == 7 || c == 11));
            chk($sformatf("idle_po_c%0d", c), 32'(po_flag), 0);
            chk($sformatf("idle_gnt_c%0d", c), 32'(gnt), 0);
            adv();
        end

        // Table-driven single-requester timeline.
        req = 4'b0001;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            chk($sformatf("tbl_tick_c%0d", c), 32'(tick), 32'(tbl[c].exp_tick));
            chk($sformatf("tbl_gnt_c%0d", c), 32'(gnt), 32'(tbl[c].exp_gnt));
            chk($sformatf("tbl_po_c%0d", c), 32'(po_flag), 32'(tbl[c].exp_po));
            req = tbl[c].req;
            adv();
        end

        // All four requesting: rotation 0,1,2,3,0 with three flags each.
        req = 4'b1111;
        do_reset();
        owners.delete();
        po_cnt = 0; onehot_bad = 0; idle_tick_seen = 0; prev_busy = 0;
        for (int c = 0; c < 84; c++) begin
            if ($countones(gnt) > 1) onehot_bad++;
            if (busy && !prev_busy) begin
                owners.push_back(int'(owner_id));
                chk("rot_gnt_match", 32'(gnt), 32'(4'b0001 << owner_id));
                chk("rot_idle_tick_gap", 32'(idle_tick_seen), 1);
                po_cnt = 0;
                idle_tick_seen = 0;
            end
            if (!busy && prev_busy) chk("rot_flags", 32'(po_cnt), 3);
            if (busy && po_flag) po_cnt++;
            if (!busy && tick) idle_tick_seen = 1;
            prev_busy = busy;
            adv();
        end
        chk("rot_onehot", 32'(onehot_bad), 0);
        chk("rot_grant_count", 32'(owners.size() >= 5), 1);
        for (int i = 0; i < 5 && i < owners.size(); i++)
            chk($sformatf("rot_owner%0d", i), 32'(owners[i]), 32'(i % 4));

        // Owner 2 drops its request two cycles after grant.
        req = 4'b0100;
        do_reset();
        po_cnt = 0;
        for (int c = 0; c < 4; c++) adv();
        chk("drop_gnt_c4", 32'(gnt), 32'(4'b0100));
        for (int c = 4; c < 6; c++) begin
            if (po_flag) po_cnt++;
            adv();
        end
        if (po_flag) po_cnt++;
        req = 4'b0001;
        adv();
        chk("drop_gnt_c7", 32'(gnt), 0);
        chk("drop_busy_c7", 32'(busy), 0);
        chk("drop_flags", 32'(po_cnt), 0);
        adv();
        chk("drop_regrant_c8", 32'(gnt), 32'(4'b0001));
        chk("drop_owner_c8", 32'(owner_id), 0);

        // cfg_load with ratio 0 mid-grant, then ratio 6 coinciding with a tick.
        req = 4'b0001;
        do_reset();
        for (int c = 0; c < 5; c++) adv();
        chk("cfg_busy_c5", 32'(busy), 1);
        cfg_div = 8'd0; cfg_load = 1'b1;
        adv();
        cfg_load = 1'b0;
        po_cnt = 0;
        for (int c = 6; c < 9; c++) begin
            chk($sformatf("cfg_tick1_c%0d", c), 32'(tick), 1);
            chk($sformatf("cfg_busy_c%0d", c), 32'(busy), 1);
            if (po_flag) po_cnt++;
            adv();
        end
        chk("cfg_release_c9", 32'(busy), 0);
        chk("cfg_flags", 32'(po_cnt), 3);
        chk("cfg_tick_c9", 32'(tick), 1);
        cfg_div = 8'd6; cfg_load = 1'b1;
        adv();
        cfg_load = 1'b0;
        chk("cfg_coincide_grant_c10", 32'(busy), 1);
        for (int c = 10; c < 22; c++) begin
            chk($sformatf("cfg_tick6_c%0d", c), 32'(tick), 32'(c == 15 || c == 21));
            adv();
        end

        // Reset during ownership.
        req = 4'b1111;
        do_reset();
        for (int c = 0; c < 22; c++) adv();
        chk("midrst_owner1", 32'(gnt), 32'(4'b0010));
        rst = 1'b1;
        adv();
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_tick", 32'(tick), 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) adv();
        chk("midrst_gnt_c3", 32'(gnt), 0);
        adv();
        chk("midrst_gnt_c4", 32'(gnt), 32'(4'b0001));

        // Randomized run against the reference model.
        rst = 1'b1; req = 4'b0000; cfg_load = 1'b0;
        model_step();
        adv();
        for (int n = 0; n < 4000; n++) begin
            e_gnt = '0;
            if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
            chk("rnd_tick", 32'(tick), 32'(m_phase == m_period - 1));
            chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
            chk("rnd_busy", 32'(busy), 32'(m_owner >= 0));
            chk("rnd_po", 32'(po_flag), 32'((m_phase == m_period - 1) && m_owner >= 0));
            if (m_owner >= 0) chk("rnd_owner", 32'(owner_id), 32'(m_last));
            rst      = ($urandom_range(0, 399) == 0);
            cfg_load = ($urandom_range(0, 29) == 0);
            cfg_div  = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
            model_step();
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tick_rr_arbiter.md
Name: tick_rr_arbiter

Overview:
- Shares the flag-gated AND datapath (the div_clk/a_and_b pair) between NREQ requesters.
- Generates the periodic enable tick from a runtime-programmable divide ratio.
- Grants the datapath to one requester at a time, round-robin, aligned to tick boundaries.
- Forwards the tick as the datapath enable only while a grant is active. Sits between requester logic and the gated datapath, replacing the fixed divider.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- DIV_W, 8: width of the divide-ratio register.
- DEF_DIV, 4: divide ratio after reset.
- OWN_TICKS, 3: maximum ticks one owner may hold the datapath per grant, 1..255.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous reset, active-high.
- cfg_div  in  DIV_W  new divide ratio; 0 is treated as 1.
- cfg_load  in  1  one-cycle strobe; loads cfg_div.
- req  in  NREQ  request per requester; held high until the requester is done.
- gnt  out  NREQ  one-hot grant, registered.
- owner_id  out  3  index of the current owner, valid while busy.
- busy  out  1  high while any grant is active.
- tick  out  1  free-running divided tick, one cycle wide.
- po_flag  out  1  datapath enable, equal to tick AND busy.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. At any clk edge with rst=1:
  - cnt=0, div_r=DEF_DIV, state=IDLE, ptr=0, own_cnt=0.
  - gnt=0, owner_id=0, busy=0, tick=0, po_flag=0.
  - Reset mid-grant drops gnt on that edge; the in-flight owner gets no completion indication.
- Divider:
  - cnt counts 0..div_r-1, then wraps to 0.
  - tick = (cnt == div_r-1), decoded from registered state.
  - div_r=1 gives tick high every cycle.
- cfg_load:
  - On the edge, div_r <= max(cfg_div,1) and cnt <= 0.
  - The old ratio's pending tick is discarded.
  - If cfg_load and tick coincide, the tick in that cycle still counts for the arbiter.
- FSM states: IDLE, OWN.
- IDLE:
  - If tick=1 and req!=0 in cycle T: select the first set req bit scanning ptr, ptr+1, … mod NREQ.
  - From T+1: gnt=onehot(sel), owner_id=sel, busy=1, own_cnt=0, state=OWN.
  - If tick=0 or req=0, stay in IDLE.
  - req raised between ticks waits for the next tick; worst-case grant latency is div_r cycles.
- OWN:
  - gnt is held constant.
  - po_flag = tick in each cycle.
  - Each tick increments own_cnt.
  - Release condition A: req[owner]=0 in any cycle.
  - Release condition B: tick=1 and own_cnt==OWN_TICKS-1, i.e. the owner has received exactly OWN_TICKS flags.
  - On release edge: gnt=0, busy=0, state=IDLE, ptr=(owner+1) mod NREQ.
  - If A and B coincide, release once; ptr advances once.
- No back-to-back grant: a release and a new grant never share a cycle. The next grant needs a later tick in IDLE, which guarantees a gap of at least one tick between owners.
- Requests from non-owners during OWN are ignored; no queueing beyond the held req levels.
- gnt is always zero or one-hot; owner_id matches the gnt bit.
- Widths:
  - cnt and div_r are DIV_W bits.
  - own_cnt is 8 bits.
  - ptr and owner_id are 3 bits; upper bits are zero when NREQ<8.

Test Plan:
- Reset then idle, DEF_DIV=4, req=0:
  - tick high at cycles 3, 7, 11 after rst release; po_flag never high; gnt=0.
- req=4'b0001 held:
  - At tick at cycle 3, gnt=0001 from cycle 4.
  - po_flag at cycles 7, 11, 15.
  - Release at cycle 16 (OWN_TICKS=3); ptr=1.
  - Re-grant at tick cycle 19.
- req=4'b1111 held throughout:
  - Owners rotate 0, 1, 2, 3, 0.
  - Each owner receives exactly 3 po_flag pulses.
  - gnt is never more than one-hot and is never asserted in two consecutive owner sequences without an idle tick between them.
- Owner 2 drops req two cycles after grant:
  - gnt falls on the next edge with zero po_flag pulses; ptr=3.
  - Requester 0 (held) is granted at the next tick.
- cfg_load with cfg_div=0 mid-grant:
  - tick every cycle from the following cycle; the owner is released 3 cycles later.
  - cfg_div=6 then gives a tick period of 6.
- rst asserted during OWN with req=1111:
  - Next edge: gnt=0, busy=0, tick=0.
  - After release, the first grant goes to requester 0 (ptr=0) at cycle 4.
